upg_load_ctrl: RTL and testbench
================================

Name: upg_load_ctrl

Overview:
- Sequences UART programming of the instruction memory (prgrom).
- Takes a byte stream from the UART receiver, decodes a 2-byte word-count header, packs bytes little-endian into 32-bit words, and drives write enable, address and data for the ROM write port.
- Drives kickoff_o. External muxes use it to decide whether the CPU fetch port (1) or the loader (0) owns the ROM.
- Sits between the UART receiver and the programrom wrapper, in the upg_clk_i domain.

Parameters:
- ADDR_W, 14, ROM word-address width.
- DEPTH, 16384, ROM depth in words; the largest legal word count.
- CNT_W, 16, header word-count width.
- TIMEOUT, 1000000, idle cycles allowed between bytes during a load (100 ms at 10 MHz).

Ports:
- upg_clk_i  in  1  UPG clock (10 MHz).
- upg_rst_n_i  in  1  Reset; asynchronous, active-low.
- start_i  in  1  One-cycle pulse that arms a new load.
- rx_data_i  in  8  UART received byte.
- rx_valid_i  in  1  One-cycle strobe; rx_data_i is valid.
- upg_wen_o  out  1  ROM write enable.
- upg_adr_o  out  ADDR_W  ROM word address.
- upg_dat_o  out  32  ROM write data.
- upg_done_o  out  1  Last load completed successfully.
- kickoff_o  out  1  1 = CPU owns the ROM; 0 = loader owns it.
- busy_o  out  1  Load in progress.
- err_o  out  1  Last load aborted.

Behaviour:
- Reset values: state IDLE. upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o = 0. kickoff_o = 1. All internal counters = 0.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR. All outputs are registered.
- kickoff_o = 1 in IDLE, DONE and ERR; otherwise 0. busy_o = !kickoff_o. upg_done_o = 1 only in DONE. err_o = 1 only in ERR.
- IDLE/DONE/ERR, start_i=1 → HDR0. Clears upg_adr_o, byte index, word count and idle counter. In these states rx_valid_i is ignored, and a same-cycle rx_valid_i is dropped in favour of start_i.
- HDR0, rx_valid_i → count[7:0] = rx_data_i, then HDR1. HDR0 has no timeout.
- HDR1, rx_valid_i → count[15:8] = rx_data_i, then:
  - full count == 0 → DONE;
  - count > DEPTH → ERR;
  - otherwise → DATA with byte index = 0.
- DATA, rx_valid_i → rx_data_i is stored in byte lane [8*idx +: 8] and idx is incremented. On the 4th byte (idx == 3) the FSM goes to WRITE, and upg_dat_o is loaded with the full word that same edge.
- WRITE lasts exactly 1 cycle, with upg_wen_o = 1 and upg_adr_o/upg_dat_o stable. On exit:
  - upg_adr_o increments and remaining count decrements;
  - remaining == 0 → DONE, otherwise → DATA;
  - an rx_valid_i arriving during WRITE is accepted as byte 0 of the next word (idx becomes 1); no byte may be lost.
- Write latency: upg_wen_o rises exactly 1 cycle after the 4th byte strobe.
- Timeout, in HDR1/DATA/WRITE: the idle counter increments each cycle without rx_valid_i and clears on rx_valid_i. Reaching TIMEOUT → ERR. A partial word is discarded and no write is issued.
- start_i in HDR0..WRITE is ignored.
- Address wrap cannot occur: count ≤ DEPTH guarantees the last address is DEPTH-1, and upg_adr_o stops incrementing after the final write.
- Async reset mid-load: immediate return to IDLE with kickoff_o = 1. Already-written words remain in ROM.

Decomposition:
- Shared package upg_pkg holds:
  - state enum upg_state_t;
  - UPG_BYTE_W = 8, UPG_HDR_BYTES = 2, UPG_WORD_BYTES = 4.
- One sub-module, upg_word_packer, does the byte-lane insert, byte index and word-complete flag, with a clear input.
- The FSM, counters and timeout stay in the top module.

Test Plan:
- Reset, no start → kickoff_o=1, upg_wen_o=0, all other outputs 0 for 100 cycles.
- start; bytes 02 00 | 78 56 34 12 | EF BE AD DE → wen pulse at adr 0 with data 0x12345678, then at adr 1 with data 0xDEADBEEF. Each pulse is 1 cycle, 1 cycle after the 4th byte. Then DONE with upg_done_o=1, kickoff_o=1.
- Header 00 00 → DONE with no wen pulse. Header 01 40 (16385) → ERR with err_o=1 and no wen pulse.
- Load 2 words with the next byte strobed during the WRITE cycle → both words written correctly, no dropped byte.
- TIMEOUT=16: after 2 data bytes, stall 16 cycles → ERR, no wen pulse. A following start plus a valid load recovers to DONE.
- Deassert upg_rst_n_i mid-DATA → all outputs return to reset values asynchronously. start_i during DATA is ignored.

Source files
------------

// File: rtl/upg_pkg.sv
// Shared types and constants for the UART program loader.
package upg_pkg;

  localparam int UPG_BYTE_W     = 8;
  localparam int UPG_HDR_BYTES  = 2;
  localparam int UPG_WORD_BYTES = 4;
  localparam int UPG_WORD_W     = UPG_BYTE_W * UPG_WORD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } upg_state_t;

  // Status outputs are a pure function of the state being entered.
  typedef struct packed {
    logic kickoff;
    logic busy;
    logic done;
    logic err;
  } upg_flags_t;

  function automatic upg_flags_t upg_flags(input upg_state_t s);
    upg_flags_t f;
    f.kickoff = (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    f.busy    = !f.kickoff;
    f.done    = (s == ST_DONE);
    f.err     = (s == ST_ERR);
    return f;
  endfunction

endpackage

// File: rtl/upg_word_packer.sv
// Packs a stream of bytes little-endian into 32-bit words.
// word_o is the current partial word with the incoming byte already
// inserted, so the caller can capture a complete word on the edge
// that accepts its last byte.
module upg_word_packer
  import upg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [UPG_BYTE_W-1:0] byte_i,
  output logic [UPG_WORD_W-1:0] word_o,
  output logic                  word_done_o
);

  localparam int IDX_W = $clog2(UPG_WORD_BYTES);

  logic [UPG_WORD_W-1:0] word_reg;
  logic [UPG_WORD_W-1:0] word_next;
  logic [IDX_W-1:0]      idx_reg;

  // Replace only the lane addressed by the byte index.
  for (genvar gi = 0; gi < UPG_WORD_BYTES; gi++) begin : g_lane
    assign word_next[gi*UPG_BYTE_W +: UPG_BYTE_W] =
      (idx_reg == IDX_W'(gi)) ? byte_i : word_reg[gi*UPG_BYTE_W +: UPG_BYTE_W];
  end

  assign word_o      = word_next;
  assign word_done_o = byte_valid_i && (idx_reg == IDX_W'(UPG_WORD_BYTES - 1));

  // Byte index wraps naturally back to lane 0 after the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (clr_i) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (byte_valid_i) begin
      word_reg <= word_next;
      idx_reg  <= idx_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/upg_load_ctrl.sv
// UART program loader: decodes a 2-byte little-endian word-count header,
// packs the following bytes into 32-bit words and writes them to the
// instruction ROM. kickoff_o hands the ROM back to the CPU when idle.
module upg_load_ctrl
  import upg_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 16384,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  upg_clk_i,
  input  logic                  upg_rst_n_i,
  input  logic                  start_i,
  input  logic [UPG_BYTE_W-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  upg_wen_o,
  output logic [ADDR_W-1:0]     upg_adr_o,
  output logic [UPG_WORD_W-1:0] upg_dat_o,
  output logic                  upg_done_o,
  output logic                  kickoff_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  upg_state_t            state_reg;
  upg_flags_t            flags_reg;
  logic [UPG_BYTE_W-1:0] hdr_lo_reg;
  logic [CNT_W-1:0]      remain_reg;
  logic [IDLE_W-1:0]     idle_reg;
  logic                  wen_reg;
  logic [ADDR_W-1:0]     adr_reg;
  logic [UPG_WORD_W-1:0] dat_reg;

  logic                  pk_clr;
  logic                  pk_valid;
  logic [UPG_WORD_W-1:0] pk_word;
  logic                  pk_done;
  logic [CNT_W-1:0]      hdr_count;
  logic                  over_depth;
  logic                  idle_expired;

  // The packer only holds bytes while a data phase is in progress; any
  // other state (including ERR after a timeout) discards a partial word.
  assign pk_clr   = !((state_reg == ST_DATA) || (state_reg == ST_WRITE));
  assign pk_valid = rx_valid_i && !pk_clr;

  upg_word_packer u_packer (
    .clk          (upg_clk_i),
    .rst_n        (upg_rst_n_i),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data_i),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  assign hdr_count    = CNT_W'({rx_data_i, hdr_lo_reg});
  assign over_depth   = ({1'b0, hdr_count} > (CNT_W + 1)'(DEPTH));
  assign idle_expired = !rx_valid_i && (idle_reg == IDLE_W'(TIMEOUT - 1));

  // Load sequencer: header decode, word writes, timeout and status flags.
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      state_reg  <= ST_IDLE;
      flags_reg  <= upg_flags(ST_IDLE);
      hdr_lo_reg <= '0;
      remain_reg <= '0;
      idle_reg   <= '0;
      wen_reg    <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Bytes arriving outside a load are dropped.
          if (start_i) begin
            state_reg  <= ST_HDR0;
            flags_reg  <= upg_flags(ST_HDR0);
            hdr_lo_reg <= '0;
            remain_reg <= '0;
            idle_reg   <= '0;
            adr_reg    <= '0;
          end
        end

        ST_HDR0: begin
          // Waits indefinitely for the first header byte.
          if (rx_valid_i) begin
            hdr_lo_reg <= rx_data_i;
            idle_reg   <= '0;
            state_reg  <= ST_HDR1;
            flags_reg  <= upg_flags(ST_HDR1);
          end
        end

        ST_HDR1: begin
          if (rx_valid_i) begin
            remain_reg <= hdr_count;
            idle_reg   <= '0;
            if (hdr_count == '0) begin
              state_reg <= ST_DONE;
              flags_reg <= upg_flags(ST_DONE);
            end else if (over_depth) begin
              state_reg <= ST_ERR;
              flags_reg <= upg_flags(ST_ERR);
            end else begin
              state_reg <= ST_DATA;
              flags_reg <= upg_flags(ST_DATA);
            end
          end else if (idle_expired) begin
            state_reg <= ST_ERR;
            flags_reg <= upg_flags(ST_ERR);
          end else begin
            idle_reg <= idle_reg + IDLE_W'(1);
          end
        end

        ST_DATA: begin
          if (rx_valid_i) begin
            idle_reg <= '0;
            if (pk_done) begin
              dat_reg   <= pk_word;
              wen_reg   <= 1'b1;
              state_reg <= ST_WRITE;
              flags_reg <= upg_flags(ST_WRITE);
            end
          end else if (idle_expired) begin
            state_reg <= ST_ERR;
            flags_reg <= upg_flags(ST_ERR);
          end else begin
            idle_reg <= idle_reg + IDLE_W'(1);
          end
        end

        ST_WRITE: begin
          // Single write cycle; a byte arriving now went into the packer.
          wen_reg    <= 1'b0;
          remain_reg <= remain_reg - CNT_W'(1);
          idle_reg   <= rx_valid_i ? '0 : idle_reg + IDLE_W'(1);
          if (remain_reg == CNT_W'(1)) begin
            // Address holds at the last written word so it never wraps.
            state_reg <= ST_DONE;
            flags_reg <= upg_flags(ST_DONE);
          end else begin
            adr_reg <= adr_reg + ADDR_W'(1);
            if (idle_expired) begin
              state_reg <= ST_ERR;
              flags_reg <= upg_flags(ST_ERR);
            end else begin
              state_reg <= ST_DATA;
              flags_reg <= upg_flags(ST_DATA);
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          flags_reg <= upg_flags(ST_IDLE);
          wen_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign upg_wen_o  = wen_reg;
  assign upg_adr_o  = adr_reg;
  assign upg_dat_o  = dat_reg;
  assign upg_done_o = flags_reg.done;
  assign kickoff_o  = flags_reg.kickoff;
  assign busy_o     = flags_reg.busy;
  assign err_o      = flags_reg.err;

endmodule

// File: tb/tb_upg_load_ctrl.sv
// Directed bench for the UART program loader (short timeout of 16 cycles).
module tb_upg_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wen;
  logic [13:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        kickoff;
  logic        busy;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int wen_cnt     = 0;
  int wen_base;
  int bad;

  always #5 clk = ~clk;

  upg_load_ctrl #(
    .ADDR_W  (14),
    .DEPTH   (16384),
    .CNT_W   (16),
    .TIMEOUT (16)
  ) dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .start_i     (start),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .upg_wen_o   (wen),
    .upg_adr_o   (adr),
    .upg_dat_o   (dat),
    .upg_done_o  (done),
    .kickoff_o   (kickoff),
    .busy_o      (busy),
    .err_o       (err)
  );

  // Counts cycles with the write enable high.
  always @(negedge clk) if (wen) wen_cnt <= wen_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp_kbde);
    chk(tag, {kickoff, busy, done, err}, {28'd0, exp_kbde});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    #12;
    chk("rst_outputs", {wen, done, kickoff, busy, err}, 32'b00100);
    chk("rst_adr_dat", {18'd0, adr} | dat, 32'd0);
    rst_n = 1'b1;

    // Idle with no start: nothing changes for 100 cycles.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({wen, done, kickoff, busy, err} !== 5'b00100 || adr !== 14'd0 || dat !== 32'd0) bad++;
    end
    chk("idle_100", bad, 0);

    // Two-word load with gaps between bytes.
    wen_base = wen_cnt;
    pulse_start();
    check_status("armed_hdr0", 4'b0100);
    send_byte(8'h02); tick(); send_byte(8'h00); tick();
    send_byte(8'h78); send_byte(8'h56); tick(); send_byte(8'h34);
    chk("w0_pre_wen", wen, 0);
    send_byte(8'h12);
    chk("w0_wen", wen, 1);
    chk("w0_adr", adr, 0);
    chk("w0_dat", dat, 32'h12345678);
    tick();
    chk("w0_wen_low", wen, 0);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    chk("w1_wen", wen, 1);
    chk("w1_adr", adr, 1);
    chk("w1_dat", dat, 32'hDEADBEEF);
    tick();
    chk("w1_wen_low", wen, 0);
    check_status("load2_done", 4'b1010);
    chk("load2_adr_hold", adr, 1);
    chk("load2_wen_cycles", wen_cnt - wen_base, 2);

    // Zero-length header completes immediately.
    wen_base = wen_cnt;
    pulse_start();
    check_status("zero_armed", 4'b0100);
    send_byte(8'h00); send_byte(8'h00);
    check_status("zero_done", 4'b1010);
    tick();
    chk("zero_no_wen", wen_cnt - wen_base, 0);

    // 16385 words exceeds the ROM.
    pulse_start();
    send_byte(8'h01); send_byte(8'h40);
    check_status("over_err", 4'b1001);
    tick();
    chk("over_no_wen", wen_cnt - wen_base, 0);

    // 16384 words is legal; stalling then times out exactly on cycle 16.
    pulse_start();
    send_byte(8'h00); send_byte(8'h40);
    check_status("max_data", 4'b0100);
    repeat (15) tick();
    check_status("max_idle15", 4'b0100);
    tick();
    check_status("max_idle16_err", 4'b1001);

    // Back-to-back bytes; the 5th byte arrives during the write cycle.
    wen_base = wen_cnt;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("b2b_w0_wen", wen, 1);
    chk("b2b_w0_dat", dat, 32'h44332211);
    send_byte(8'h55);
    chk("b2b_w0_wen_low", wen, 0);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    chk("b2b_w1_wen", wen, 1);
    chk("b2b_w1_adr", adr, 1);
    chk("b2b_w1_dat", dat, 32'h88776655);
    tick();
    check_status("b2b_done", 4'b1010);
    chk("b2b_wen_cycles", wen_cnt - wen_base, 2);

    // Timeout after a partial word, then a clean recovery load.
    wen_base = wen_cnt;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (15) tick();
    check_status("to_idle15", 4'b0100);
    tick();
    check_status("to_err", 4'b1001);
    chk("to_no_wen", wen_cnt - wen_base, 0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("rec_wen", wen, 1);
    chk("rec_adr", adr, 0);
    chk("rec_dat", dat, 32'h04030201);
    tick();
    check_status("rec_done", 4'b1010);

    // start during DATA is ignored: the word still completes intact.
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2);
    pulse_start();
    check_status("ign_start_busy", 4'b0100);
    send_byte(8'hA3); send_byte(8'hA4);
    chk("ign_start_wen", wen, 1);
    chk("ign_start_dat", dat, 32'hA4A3A2A1);
    tick();
    send_byte(8'hB1);

    // Asynchronous reset mid-DATA, checked before any further clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {wen, done, kickoff, busy, err}, 32'b00100);
    chk("arst_adr", adr, 0);
    chk("arst_dat", dat, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_status("arst_idle", 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
